row_addr_setter: RTL and testbench

Responder side of the readout sequencer's row-select handshake. The sequencer presents `ROWADD` and raises `SET_ROW`. This block then:
- latches the address,
- shifts it serially into the sensor's on-chip row decoder,
- strobes the decoder load,
- answers with `SET_ROW_DONE`.

It sits between the ADC-readout mux and the sensor pads, one instance per sensor.

---
 rtl/row_set_pkg.sv | 20 ++
 rtl/row_shift_ser.sv | 75 +++++++
 rtl/row_addr_setter.sv | 144 ++++++++++++++
 tb/tb_row_addr_setter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/row_set_pkg.sv
// Shared types and defaults for the row-select responder.
package row_set_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } row_state_e;

  localparam int ADDR_W_DEF  = 9;
  localparam int CLK_DIV_DEF = 2;
  localparam int LOAD_W_DEF  = 2;

  // Edges from request acceptance to the rising acknowledge on a full transfer.
  function automatic int ack_latency(input int addr_w, input int clk_div, input int load_w);
    return 1 + 2 * clk_div * addr_w + load_w;
  endfunction

endpackage

// File: rtl/row_shift_ser.sv
// MSB-first serialiser for the sensor row decoder; ROW_SDATA only moves on
// the falling ROW_SCLK edge so it is stable a full half-period before each rise.
module row_shift_ser
  import row_set_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              TX_CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] data,
  output logic              ROW_SCLK,
  output logic              ROW_SDATA,
  output logic              shift_done
);

  localparam int BIT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [ADDR_W-1:0] sreg_r;
  logic [PH_W-1:0]   ph_r;
  logic [BIT_W-1:0]  bit_r;
  logic              active_r;
  logic              sclk_r;
  logic              sdata_r;
  logic              ph_end_s;
  logic              last_bit_s;

  assign ph_end_s   = (ph_r == PH_W'(CLK_DIV - 1));
  assign last_bit_s = (bit_r == BIT_W'(ADDR_W - 1));
  // Valid during the final cycle of the last bit's high phase.
  assign shift_done = active_r & sclk_r & ph_end_s & last_bit_s;

  assign ROW_SCLK  = sclk_r;
  assign ROW_SDATA = sdata_r;

  // Shift register, half-period phase counter and bit counter.
  always_ff @(posedge TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r   <= '0;
      ph_r     <= '0;
      bit_r    <= '0;
      active_r <= 1'b0;
      sclk_r   <= 1'b0;
      sdata_r  <= 1'b0;
    end else if (start) begin
      sreg_r   <= data << 1;
      sdata_r  <= data[ADDR_W-1];
      sclk_r   <= 1'b0;
      ph_r     <= '0;
      bit_r    <= '0;
      active_r <= 1'b1;
    end else if (active_r) begin
      if (!ph_end_s) begin
        ph_r <= ph_r + PH_W'(1);
      end else begin
        ph_r <= '0;
        if (!sclk_r) begin
          sclk_r <= 1'b1;
        end else begin
          sclk_r <= 1'b0;
          if (last_bit_s) begin
            active_r <= 1'b0;
          end else begin
            bit_r   <= bit_r + BIT_W'(1);
            sdata_r <= sreg_r[ADDR_W-1];
            sreg_r  <= sreg_r << 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/row_addr_setter.sv
// Row-select handshake responder: accept, serialise, load, acknowledge.
// Optional ROW_SET_SKIP_SAME_EN acknowledges a repeat of the last loaded row at once.
module row_addr_setter
  import row_set_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int LOAD_W  = LOAD_W_DEF
) (
  input  logic              TX_CLK,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ROWADD,
  input  logic              SET_ROW,
  output logic              SET_ROW_DONE,
  output logic              ROW_SCLK,
  output logic              ROW_SDATA,
  output logic              ROW_LOAD,
  output logic              ROW_BUSY
);

  localparam int LCNT_W = (LOAD_W > 1) ? $clog2(LOAD_W) : 1;

  row_state_e        state_r;
  logic [1:0]        rst_pipe_r;
  logic              rst_int_n;
  logic [LCNT_W-1:0] load_cnt_r;
  logic              load_r;
  logic              done_r;
  logic              busy_r;
  logic              skip_s;
  logic              start_s;
  logic              shift_done_s;
  logic              load_end_s;

  // Reset synchroniser: asserts asynchronously, releases on a clock edge.
  always_ff @(posedge TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_r <= 2'b00;
    end else begin
      rst_pipe_r <= {rst_pipe_r[0], 1'b1};
    end
  end

  assign rst_int_n  = rst_pipe_r[1];
  assign load_end_s = (state_r == LOAD) && (load_cnt_r == LCNT_W'(LOAD_W - 1));

`ifdef ROW_SET_SKIP_SAME_EN
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] last_addr;
  logic              last_vld;

  assign skip_s = last_vld && (ROWADD == last_addr);

  // Remember what the decoder currently holds; valid only once a load completes.
  always_ff @(posedge TX_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      addr_r    <= '0;
      last_addr <= '0;
      last_vld  <= 1'b0;
    end else begin
      if (start_s) begin
        addr_r <= ROWADD;
      end
      if (load_end_s) begin
        last_addr <= addr_r;
        last_vld  <= 1'b1;
      end
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  assign start_s = (state_r == IDLE) && SET_ROW && !skip_s;

  row_shift_ser #(
    .ADDR_W (ADDR_W),
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .TX_CLK    (TX_CLK),
    .rst_n     (rst_int_n),
    .start     (start_s),
    .data      (ROWADD),
    .ROW_SCLK  (ROW_SCLK),
    .ROW_SDATA (ROW_SDATA),
    .shift_done(shift_done_s)
  );

  // Handshake FSM; acknowledge is raised one edge after DONE is entered.
  always_ff @(posedge TX_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_r    <= IDLE;
      load_cnt_r <= '0;
      load_r     <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          load_r <= 1'b0;
          if (SET_ROW) begin
            busy_r  <= 1'b1;
            state_r <= skip_s ? DONE : SHIFT;
          end else begin
            busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_done_s) begin
            load_r     <= 1'b1;
            load_cnt_r <= '0;
            state_r    <= LOAD;
          end
        end
        LOAD: begin
          if (load_end_s) begin
            load_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            load_cnt_r <= load_cnt_r + LCNT_W'(1);
          end
        end
        DONE: begin
          if (!done_r) begin
            done_r <= 1'b1;
          end else if (!SET_ROW) begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign SET_ROW_DONE = done_r;
  assign ROW_LOAD     = load_r;
  assign ROW_BUSY     = busy_r;

endmodule

// File: tb/tb_row_addr_setter.sv
// Directed bench: a default instance and a CLK_DIV=1/LOAD_W=1 instance share stimulus.
module tb_row_addr_setter;

  logic       TX_CLK = 1'b0;
  logic       rst_n  = 1'b0;
  logic [8:0] ROWADD = 9'h000;
  logic       SET_ROW = 1'b0;
  logic [1:0] done_s, sclk_s, sdata_s, load_s, busy_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 TX_CLK = ~TX_CLK;

  row_addr_setter #(.ADDR_W(9), .CLK_DIV(2), .LOAD_W(2)) dut (
    .TX_CLK(TX_CLK), .rst_n(rst_n), .ROWADD(ROWADD), .SET_ROW(SET_ROW),
    .SET_ROW_DONE(done_s[0]), .ROW_SCLK(sclk_s[0]), .ROW_SDATA(sdata_s[0]),
    .ROW_LOAD(load_s[0]), .ROW_BUSY(busy_s[0]));

  row_addr_setter #(.ADDR_W(9), .CLK_DIV(1), .LOAD_W(1)) dut_fast (
    .TX_CLK(TX_CLK), .rst_n(rst_n), .ROWADD(ROWADD), .SET_ROW(SET_ROW),
    .SET_ROW_DONE(done_s[1]), .ROW_SCLK(sclk_s[1]), .ROW_SDATA(sdata_s[1]),
    .ROW_LOAD(load_s[1]), .ROW_BUSY(busy_s[1]));

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_outs_u%0d", tag, d),
          {done_s[d], sclk_s[d], sdata_s[d], load_s[d], busy_s[d]}, 0);
  endtask

  // One request; edge 0 is the acceptance edge. drop_at<0 holds SET_ROW until
  // the default instance acknowledges. lat_* of 1 means a skipped transfer.
  task automatic run_txn(input string tag, input logic [8:0] addr, input int drop_at,
                         input int chg_at, input int lat_d, input int lat_f);
    int lat[2], div[2], lw[2], first_done[2], hold[2], loadw[2], edges[2], bad[2], last_chg[2];
    logic [8:0] cap[2];
    logic prev_sclk[2], prev_sdata[2];
    lat = '{lat_d, lat_f};
    div = '{2, 1};
    lw  = '{2, 1};
    for (int d = 0; d < 2; d++) begin
      first_done[d] = -1; hold[d] = 0; loadw[d] = 0; edges[d] = 0; bad[d] = 0;
      last_chg[d] = -100; cap[d] = 9'h000;
      prev_sclk[d] = sclk_s[d]; prev_sdata[d] = sdata_s[d];
    end
    ROWADD  = addr;
    SET_ROW = 1'b1;
    for (int k = 0; k <= lat_d + 3; k++) begin
      @(posedge TX_CLK); #1;
      for (int d = 0; d < 2; d++) begin
        if (sdata_s[d] !== prev_sdata[d]) last_chg[d] = k;
        if (sclk_s[d] && !prev_sclk[d]) begin
          edges[d]++;
          cap[d] = {cap[d][7:0], sdata_s[d]};
          if (k - last_chg[d] < div[d]) bad[d]++;
        end
        if (load_s[d]) loadw[d]++;
        if (done_s[d]) begin
          hold[d]++;
          if (first_done[d] < 0) first_done[d] = k;
        end
        if (k == 0) chk($sformatf("%s_busy_u%0d", tag, d), busy_s[d], 1);
        prev_sclk[d] = sclk_s[d];
        prev_sdata[d] = sdata_s[d];
      end
      if (k == chg_at) ROWADD = 9'h000;
      if (k == drop_at) SET_ROW = 1'b0;
      if (drop_at < 0 && first_done[0] == k) SET_ROW = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      if (lat[d] != 1) begin
        chk($sformatf("%s_cap_u%0d", tag, d), cap[d], addr);
        chk($sformatf("%s_sclk_edges_u%0d", tag, d), edges[d], 9);
        chk($sformatf("%s_load_w_u%0d", tag, d), loadw[d], lw[d]);
      end else begin
        chk($sformatf("%s_sclk_edges_u%0d", tag, d), edges[d], 0);
        chk($sformatf("%s_load_w_u%0d", tag, d), loadw[d], 0);
      end
      chk($sformatf("%s_ack_edge_u%0d", tag, d), first_done[d], lat[d]);
      chk($sformatf("%s_ack_hold_u%0d", tag, d), hold[d],
          (drop_at >= 0) ? 1 : lat_d - lat[d] + 1);
      chk($sformatf("%s_sdata_stable_u%0d", tag, d), bad[d], 0);
      chk($sformatf("%s_idle_done_u%0d", tag, d), done_s[d], 0);
      chk($sformatf("%s_idle_busy_u%0d", tag, d), busy_s[d], 0);
    end
    repeat (2) @(posedge TX_CLK);
    #1;
  endtask

  initial begin
    int loads;
    // Reset state
    repeat (2) @(posedge TX_CLK);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge TX_CLK);
    #1;
    chk_all_zero("post_reset");

    run_txn("basic_15a", 9'h15A, -1, -1, 39, 20);
    run_txn("drop_at_10", 9'h0F3, 10, -1, 39, 20);
    run_txn("rowadd_change", 9'h15A, -1, 5, 39, 20);

    // Reset pulse 20 edges into the transfer
    ROWADD  = 9'h1FF;
    SET_ROW = 1'b1;
    repeat (21) @(posedge TX_CLK);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    loads = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge TX_CLK); #1;
      if (load_s != 2'b00 || done_s != 2'b00) loads++;
    end
    chk("mid_reset_no_load_ack", loads, 0);
    SET_ROW = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge TX_CLK);
    #1;
    chk_all_zero("after_mid_reset");
    run_txn("after_reset_001", 9'h001, -1, -1, 39, 20);

    // Back-to-back identical rows
    run_txn("same_first", 9'h0A0, -1, -1, 39, 20);
`ifdef ROW_SET_SKIP_SAME_EN
    run_txn("same_second", 9'h0A0, -1, -1, 1, 1);
`else
    run_txn("same_second", 9'h0A0, -1, -1, 39, 20);
`endif
    run_txn("after_same_diff", 9'h0A1, -1, -1, 39, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
